io_fifo_unit: RTL and testbench
===============================

IO_FIFO_UNIT -- requirements
Module: io_fifo_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the byte-channel width (1..32).
REQ-002 The block SHALL have parameter IN_DEPTH, default 4, giving the input FIFO entries (power of 2, >=2).
REQ-003 The block SHALL have parameter OUT_DEPTH, default 4, giving the output FIFO entries (power of 2, >=2).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all flops rise on its positive edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ope, input, 6 bits: opcode; IN=6'b001011, OUT=6'b000011, STAT=6'b010011.
REQ-007 The block SHALL have port ds_val, input, 32 bits: source operand; OUT sends ds_val[DATA_W-1:0].
REQ-008 The block SHALL have port dd, input, 6 bits: destination register tag for IN/STAT.
REQ-009 The block SHALL have port is_busy, output, 1 bit: combinational stall request to the issue stage.
REQ-010 The block SHALL have port io_addr, output, 6 bits: registered writeback tag; 0 means no write.
REQ-011 The block SHALL have port io_dd_val, output, 32 bits: registered writeback data.
REQ-012 The block SHALL have ports io_in_data (input, DATA_W), io_in_vld (input, 1) and io_in_rdy (output, 1): the receive channel.
REQ-013 The block SHALL have ports io_out_data (output, DATA_W), io_out_vld (output, 1) and io_out_rdy (input, 1): the transmit channel.

Function
REQ-014 Receive: a byte SHALL be pushed into the input FIFO on every edge where io_in_vld && io_in_rdy.
REQ-015 io_in_rdy SHALL be registered and equal (input FIFO count after this edge) != IN_DEPTH; full blocks a push even if an IN pops in the same cycle.
REQ-016 Transmit: io_out_vld SHALL equal (output FIFO count != 0) and io_out_data SHALL be the head entry, or 0 when empty; the head pops on io_out_vld && io_out_rdy.
REQ-017 is_busy SHALL be 1 iff (ope==IN and the input FIFO is empty) or (ope==OUT and the output FIFO is full); otherwise 0.
REQ-018 A busy op SHALL have no side effect; the issue stage holds ope until is_busy drops.
REQ-019 A non-busy OUT SHALL push ds_val[DATA_W-1:0] at that edge; io_out_vld is high in the next cycle; no register writeback.
REQ-020 A non-busy IN SHALL pop the input head at that edge and drive io_addr<=dd and io_dd_val<=zero-extended byte on the same edge (1-cycle latency).
REQ-021 A byte accepted at edge N SHALL be available to an IN presented in cycle N+1.
REQ-022 io_addr SHALL return to 0 on every edge without an IN/STAT writeback; io_dd_val SHALL hold its last value.
REQ-023 On the transmit side, push and pop in the same cycle SHALL both take effect, with the count unchanged; full is judged before the pop.
REQ-024 Read/write pointers SHALL wrap modulo depth; counts SHALL be clog2(depth)+1 bits wide and SHALL never exceed depth or underflow.
REQ-025 Opcodes other than IN/OUT/STAT SHALL be ignored, with is_busy=0.

Reset
REQ-026 While rstn=0, the block SHALL hold: io_addr=0, io_dd_val=0, io_in_rdy=0, io_out_vld=0, io_out_data=0, all pointers and counts 0, and is_busy driven only by ope and the empty/full state.
REQ-027 Reset mid-transfer SHALL discard all buffered bytes; FIFO storage is not reset and is not observable.
REQ-028 io_in_rdy SHALL rise on the first edge after rstn deasserts.

Configuration
REQ-029 With IO_STAT_EN defined, STAT SHALL never be busy and SHALL write io_addr<=dd and io_dd_val<={16'b0, in_count[7:0], out_count[7:0]} in 1 cycle.
REQ-030 Without IO_STAT_EN, STAT SHALL be treated as an unknown opcode per REQ-025, and no count-readback logic SHALL exist.

Structure
REQ-031 Package io_pkg SHALL hold the OPE_IN, OPE_OUT and OPE_STAT constants, the default widths, and a TAG_W=6 constant.
REQ-032 One sub-module, sync_fifo (parameters W, DEPTH; push/pop/full/empty/count/head), SHALL be instantiated twice: once for the input FIFO and once for the output FIFO.

Verification
REQ-033 Drive io_in_vld with 8'h41 then 8'h42 and issue IN dd=5 twice -> io_addr=5 with io_dd_val=32'h41, then 32'h42, each 1 cycle after issue.
REQ-034 Issue IN with the input FIFO empty -> is_busy=1 and io_addr=0; push 8'h7F -> next cycle is_busy=0 and the writeback is 32'h7F.
REQ-035 Hold io_out_rdy=0 and issue 5 OUTs (ds_val=1..5) with OUT_DEPTH=4 -> the 5th is busy; raise rdy -> bytes 1..5 emerge in order, with no loss.
REQ-036 Hold io_in_vld high with 4 bytes and no IN -> io_in_rdy=0 after the 4th edge; one IN -> rdy returns 1 the following cycle.
REQ-037 Assert rstn=0 with 3 bytes buffered each side -> io_out_vld=0 and io_in_rdy=0 immediately; after release the FIFOs are empty and rdy=1.
REQ-038 With IO_STAT_EN, buffer in=2 and out=1, then issue STAT dd=9 -> io_addr=9 and io_dd_val=32'h0201.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared constants for the I/O FIFO unit.
//   - opcode encodings decoded by io_fifo_unit (IN / OUT / STAT)
//   - default channel width and FIFO depths
//   - writeback tag width and the registered writeback bundle type
package io_pkg;

    localparam int OPE_W         = 6;
    localparam int TAG_W         = 6;
    localparam int DATA_W_DEF    = 8;
    localparam int IN_DEPTH_DEF  = 4;
    localparam int OUT_DEPTH_DEF = 4;

    localparam logic [OPE_W-1:0] OPE_IN   = 6'b001011;
    localparam logic [OPE_W-1:0] OPE_OUT  = 6'b000011;
    localparam logic [OPE_W-1:0] OPE_STAT = 6'b010011;

    // Register-file writeback: tag 0 means "no write this cycle".
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } wb_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head (first-word fall-through).
// Ports:
//   clk, rstn      clock, async active-low reset (pointers/count only)
//   push, wdata    write request and data; ignored while full
//   pop            read request; ignored while empty
//   full, empty    status from the current count (judged before this edge)
//   count          occupancy, clog2(DEPTH)+1 bits
//   head           entry at the read pointer (stale when empty)
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en, pop_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Full/empty are taken from the pre-edge count, so a push into a full
    // FIFO is dropped even when a pop happens on the same edge.
    assign push_en = push && !full;
    assign pop_en  = pop  && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_en);
        rd_ptr_d = rd_ptr_q + PW'(pop_en);
        count_d  = count_q + CW'(push_en) - CW'(pop_en);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; a zero count hides stale entries.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/io_fifo_unit.sv
// io_fifo_unit: byte-channel I/O unit between the issue stage and a
// receive/transmit valid-ready link, buffered by two sync_fifo instances.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   ope, ds_val, dd           issued opcode, source operand, destination tag
//   is_busy                   combinational stall (IN on empty / OUT on full)
//   io_addr, io_dd_val        registered writeback tag (0 = none) and data
//   io_in_data/vld/rdy        receive channel into the input FIFO
//   io_out_data/vld/rdy       transmit channel from the output FIFO
// Build option: define IO_STAT_EN to add the STAT opcode, which writes back
// {16'b0, in_count[7:0], out_count[7:0]}. Without it STAT is ignored.
module io_fifo_unit
    import io_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IN_DEPTH  = IN_DEPTH_DEF,
    parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [OPE_W-1:0]  ope,
    input  logic [31:0]       ds_val,
    input  logic [TAG_W-1:0]  dd,
    output logic              is_busy,
    output logic [TAG_W-1:0]  io_addr,
    output logic [31:0]       io_dd_val,
    input  logic [DATA_W-1:0] io_in_data,
    input  logic              io_in_vld,
    output logic              io_in_rdy,
    output logic [DATA_W-1:0] io_out_data,
    output logic              io_out_vld,
    input  logic              io_out_rdy
);

    localparam int ICW = $clog2(IN_DEPTH) + 1;
    localparam int OCW = $clog2(OUT_DEPTH) + 1;

    logic              in_push, in_pop, in_full, in_empty;
    logic [ICW-1:0]    in_count, in_cnt_nxt;
    logic [DATA_W-1:0] in_head;
    logic              out_push, out_pop, out_full, out_empty;
    logic [OCW-1:0]    out_count;
    logic [DATA_W-1:0] out_head;

    logic              in_rdy_q, in_rdy_d;
    wb_t               wb_q, wb_d;

    logic              op_in, op_out;

    assign op_in  = (ope == OPE_IN);
    assign op_out = (ope == OPE_OUT);

    assign is_busy = (op_in && in_empty) || (op_out && out_full);

    // A busy op has no side effect, so pushes/pops only fire when not stalled.
    assign in_push  = io_in_vld && in_rdy_q;
    assign in_pop   = op_in && !in_empty;
    assign out_push = op_out && !out_full;
    assign out_pop  = !out_empty && io_out_rdy;

    sync_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (in_push),
        .wdata (io_in_data),
        .pop   (in_pop),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count),
        .head  (in_head)
    );

    sync_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (out_push),
        .wdata (ds_val[DATA_W-1:0]),
        .pop   (out_pop),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count),
        .head  (out_head)
    );

    // Ready is registered, so it is computed from the post-edge occupancy.
    assign in_cnt_nxt = in_count + ICW'(in_push) - ICW'(in_pop);

`ifdef IO_STAT_EN
    logic [7:0] in_cnt8, out_cnt8;
    assign in_cnt8  = 8'(in_count);
    assign out_cnt8 = 8'(out_count);
`endif

    always_comb begin
        in_rdy_d = (in_cnt_nxt != ICW'(IN_DEPTH));
        wb_d.tag  = '0;
        wb_d.data = wb_q.data;
        if (in_pop) begin
            wb_d.tag  = dd;
            wb_d.data = 32'(in_head);
        end
`ifdef IO_STAT_EN
        else if (ope == OPE_STAT) begin
            wb_d.tag  = dd;
            wb_d.data = {16'b0, in_cnt8, out_cnt8};
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_rdy_q <= 1'b0;
            wb_q     <= '0;
        end else begin
            in_rdy_q <= in_rdy_d;
            wb_q     <= wb_d;
        end
    end

    assign io_in_rdy   = in_rdy_q;
    assign io_addr     = wb_q.tag;
    assign io_dd_val   = wb_q.data;
    assign io_out_vld  = !out_empty;
    assign io_out_data = out_empty ? '0 : out_head;

    // Upper operand bits and status not consumed in every build.
`ifdef IO_STAT_EN
    logic unused_sig;
    assign unused_sig = ^{ds_val, in_full};
`else
    logic unused_sig;
    assign unused_sig = ^{ds_val, in_full, out_count};
`endif

endmodule

// File: tb/tb_io_fifo_unit.sv
module tb_io_fifo_unit;
    import io_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  ope;
    logic [31:0] ds_val;
    logic [5:0]  dd;
    logic        is_busy;
    logic [5:0]  io_addr;
    logic [31:0] io_dd_val;
    logic [7:0]  io_in_data;
    logic        io_in_vld;
    logic        io_in_rdy;
    logic [7:0]  io_out_data;
    logic        io_out_vld;
    logic        io_out_rdy;

    int n_vec = 0;
    int n_err = 0;

    io_fifo_unit #(.DATA_W(8), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ope         (ope),
        .ds_val      (ds_val),
        .dd          (dd),
        .is_busy     (is_busy),
        .io_addr     (io_addr),
        .io_dd_val   (io_dd_val),
        .io_in_data  (io_in_data),
        .io_in_vld   (io_in_vld),
        .io_in_rdy   (io_in_rdy),
        .io_out_data (io_out_data),
        .io_out_vld  (io_out_vld),
        .io_out_rdy  (io_out_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] got_q[$];
    logic [31:0] v;
    bit pushed5;

    initial begin
        rstn = 1'b0; ope = '0; ds_val = '0; dd = '0;
        io_in_data = '0; io_in_vld = 1'b0; io_out_rdy = 1'b0;
        tick(); tick();
        // reset state
        chk("rst_addr",  32'(io_addr), 0);
        chk("rst_val",   io_dd_val, 0);
        chk("rst_rdy",   32'(io_in_rdy), 0);
        chk("rst_ovld",  32'(io_out_vld), 0);
        chk("rst_odata", 32'(io_out_data), 0);
        chk("rst_busy0", 32'(is_busy), 0);
        ope = OPE_IN; #1;
        chk("rst_busy_in", 32'(is_busy), 1);
        ope = '0;
        rstn = 1'b1; #1;
        chk("rdy_pre_edge", 32'(io_in_rdy), 0);
        tick();
        chk("rdy_first_edge", 32'(io_in_rdy), 1);

        // two bytes in, then two INs
        io_in_vld = 1'b1; io_in_data = 8'h41; tick();
        io_in_data = 8'h42; tick();
        io_in_vld = 1'b0;
        ope = OPE_IN; dd = 6'd5; #1;
        chk("in1_busy", 32'(is_busy), 0);
        tick();
        chk("in1_addr", 32'(io_addr), 5);
        chk("in1_val",  io_dd_val, 32'h41);
        tick();
        chk("in2_addr", 32'(io_addr), 5);
        chk("in2_val",  io_dd_val, 32'h42);
        ope = '0; tick();
        chk("idle_addr", 32'(io_addr), 0);
        chk("idle_hold", io_dd_val, 32'h42);

        // IN on empty stalls, then a byte arrives
        ope = OPE_IN; dd = 6'd5; #1;
        chk("empty_busy", 32'(is_busy), 1);
        io_in_vld = 1'b1; io_in_data = 8'h7F;
        tick();
        io_in_vld = 1'b0;
        chk("stall_addr", 32'(io_addr), 0);
        chk("stall_busy_drop", 32'(is_busy), 0);
        tick();
        chk("late_addr", 32'(io_addr), 5);
        chk("late_val",  io_dd_val, 32'h7F);
        ope = '0; tick();

        // output FIFO fills, fifth OUT stalls, then drain in order
        io_out_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ope = OPE_OUT; ds_val = 32'(i) | 32'hAB00; #1;
            chk("out_fill_busy", 32'(is_busy), 0);
            tick();
            chk("out_no_wb", 32'(io_addr), 0);
        end
        chk("out_vld", 32'(io_out_vld), 1);
        chk("out_head", 32'(io_out_data), 1);
        ds_val = 32'd5; #1;
        chk("out5_busy", 32'(is_busy), 1);
        io_out_rdy = 1'b1;
        pushed5 = 1'b0;
        for (int c = 0; c < 20 && got_q.size() < 5; c++) begin
            #1;
            if (io_out_vld && io_out_rdy) got_q.push_back(io_out_data);
            if (ope == OPE_OUT && !is_busy) pushed5 = 1'b1;
            tick();
            if (pushed5) ope = '0;
        end
        chk("drain_cnt", 32'(got_q.size()), 5);
        for (int i = 0; i < 5; i++) begin
            v = (got_q.size() > i) ? 32'(got_q[i]) : 32'hFFFF;
            chk("drain_order", v, 32'(i + 1));
        end
        #1;
        chk("drain_empty", 32'(io_out_vld), 0);
        chk("drain_zero", 32'(io_out_data), 0);
        ope = '0; io_out_rdy = 1'b0;

        // input FIFO fills, ready drops, one IN reopens it
        for (int i = 0; i < 4; i++) begin
            io_in_vld = 1'b1; io_in_data = 8'h10 + 8'(i);
            tick();
            if (i == 2) chk("rdy_3_held", 32'(io_in_rdy), 1);
        end
        chk("rdy_full", 32'(io_in_rdy), 0);
        io_in_data = 8'hEE; tick();
        chk("rdy_still_full", 32'(io_in_rdy), 0);
        io_in_vld = 1'b0;
        ope = OPE_IN; dd = 6'd3;
        tick();
        chk("rdy_back", 32'(io_in_rdy), 1);
        chk("full_in_addr", 32'(io_addr), 3);
        chk("full_in_val", io_dd_val, 32'h10);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("full_drain", io_dd_val, 32'h10 + 32'(i));
        end
        chk("no_EE_busy", 32'(is_busy), 1);
        ope = '0; tick();

        // reset mid-transfer
        for (int i = 0; i < 3; i++) begin
            io_in_vld = 1'b1; io_in_data = 8'h21 + 8'(i);
            ope = OPE_OUT; ds_val = 32'h31 + 32'(i);
            tick();
        end
        io_in_vld = 1'b0; ope = '0;
        chk("pre_rst_ovld", 32'(io_out_vld), 1);
        rstn = 1'b0; #1;
        chk("mid_rst_ovld", 32'(io_out_vld), 0);
        chk("mid_rst_rdy", 32'(io_in_rdy), 0);
        chk("mid_rst_odata", 32'(io_out_data), 0);
        chk("mid_rst_val", io_dd_val, 0);
        tick();
        rstn = 1'b1;
        ope = OPE_IN; #1;
        chk("post_rst_in_empty", 32'(is_busy), 1);
        ope = '0;
        tick();
        chk("post_rst_rdy", 32'(io_in_rdy), 1);
        chk("post_rst_ovld", 32'(io_out_vld), 0);

        // STAT, and an unknown opcode
        io_in_vld = 1'b1; io_in_data = 8'h55;
        ope = OPE_OUT; ds_val = 32'h77;
        tick();
        ope = '0; io_in_data = 8'h66;
        tick();
        io_in_vld = 1'b0;
        ope = OPE_STAT; dd = 6'd9; #1;
        chk("stat_busy", 32'(is_busy), 0);
        tick();
`ifdef IO_STAT_EN
        chk("stat_addr", 32'(io_addr), 9);
        chk("stat_val",  io_dd_val, 32'h0201);
`else
        chk("stat_off_addr", 32'(io_addr), 0);
        chk("stat_off_val",  io_dd_val, 0);
`endif
        ope = 6'h3F; #1;
        chk("unk_busy", 32'(is_busy), 0);
        tick();
        chk("unk_addr", 32'(io_addr), 0);
        chk("unk_ovld", 32'(io_out_vld), 1);
        ope = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
